occupancy_ctrl: RTL and testbench

- Controller that sequences the occupancy-display datapath from two push-buttons: entry (`key_in`) and exit (`key_out`).
- Per key: synchronises, debounces and edge-detects the button.
- Arbitrates simultaneous entry/exit and maintains the current count `now_num` (0..CAPACITY) and the cumulative entry count `sum_num` (0..999, wrapping).
- Drives `full_led`.
- Generates `scan_tick`, the digit-scan enable for the seven-segment display driver.

---
 rtl/occupancy_if.sv | 23 ++
 rtl/occupancy_ctrl.sv | 201 ++++++++++++++++++++
 tb/tb_occupancy_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/occupancy_if.sv
// Button/clear inputs and count/status outputs of the occupancy controller.
interface occupancy_if;
  logic       key_in;
  logic       key_out;
  logic       clr;
  logic [5:0] now_num;
  logic [9:0] sum_num;
  logic       full_led;
  logic       in_ack;
  logic       out_ack;
  logic       reject;
  logic       scan_tick;

  modport master (
    output key_in, key_out, clr,
    input  now_num, sum_num, full_led, in_ack, out_ack, reject, scan_tick
  );

  modport slave (
    input  key_in, key_out, clr,
    output now_num, sum_num, full_led, in_ack, out_ack, reject, scan_tick
  );
endinterface

// File: rtl/occupancy_ctrl.sv
// Debounces entry/exit buttons, arbitrates them into occupancy and total-entry
// counters, and produces the display scan tick.
module occupancy_ctrl #(
  parameter int CAPACITY   = 50,
  parameter int DEB_CYCLES = 20000,
  parameter int TICK_DIV   = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  occupancy_if.slave  bus
);
  localparam int DW = $clog2(DEB_CYCLES);
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [DW-1:0] DEB_ZERO  = DW'(1'b0);
  localparam logic [DW-1:0] DEB_ONE   = DW'(1'b1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [5:0]    CAP       = 6'(CAPACITY);
  localparam logic [9:0]    SUM_MAX   = 10'd999;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    PRESSED      = 2'd2,
    WAIT_RELEASE = 2'd3
  } key_state_e;

  // Index 0 is the entry key, index 1 the exit key.
  logic [1:0]    sync1_r, sync2_r;
  key_state_e    state_r [2];
  key_state_e    state_s [2];
  logic [DW-1:0] cnt_r   [2];
  logic [DW-1:0] cnt_s   [2];
  logic [1:0]    ev_r, ev_s;

  logic [5:0]    now_r, now_s;
  logic [9:0]    sum_r, sum_s;
  logic          full_r, in_ack_r, out_ack_r, reject_r;
  logic          in_ack_s, out_ack_s, reject_s;
  logic [TW-1:0] tick_cnt_r;
  logic          scan_tick_r;

  // Decimal wrap keeps the total inside three display digits.
  function automatic logic [9:0] sum_inc(input logic [9:0] v);
    sum_inc = (v >= SUM_MAX) ? 10'd0 : v + 10'd1;
  endfunction

  // Two-flop synchronisers for both raw buttons
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 2'b00;
      sync2_r <= 2'b00;
    end else begin
      sync1_r <= {bus.key_out, bus.key_in};
      sync2_r <= sync1_r;
    end
  end

  // Debounce FSM state, counters and registered event pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        state_r[k] <= IDLE;
        cnt_r[k]   <= DEB_ZERO;
      end
      ev_r <= 2'b00;
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_r[k] <= state_s[k];
        cnt_r[k]   <= cnt_s[k];
      end
      ev_r <= ev_s;
    end
  end

  // Debounce FSM next state; an event fires only on a fully stable press
  always_comb begin
    ev_s = 2'b00;
    for (int k = 0; k < 2; k++) begin
      state_s[k] = state_r[k];
      cnt_s[k]   = cnt_r[k];
      case (state_r[k])
        IDLE: begin
          if (sync2_r[k]) begin
            state_s[k] = WAIT_PRESS;
            cnt_s[k]   = DEB_ZERO;
          end else begin
            state_s[k] = IDLE;
          end
        end
        WAIT_PRESS: begin
          if (!sync2_r[k]) begin
            state_s[k] = IDLE;
          end else if (cnt_r[k] == DEB_LAST) begin
            state_s[k] = PRESSED;
            ev_s[k]    = 1'b1;
          end else begin
            cnt_s[k] = cnt_r[k] + DEB_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_r[k]) begin
            state_s[k] = WAIT_RELEASE;
            cnt_s[k]   = DEB_ZERO;
          end else begin
            state_s[k] = PRESSED;
          end
        end
        WAIT_RELEASE: begin
          if (sync2_r[k]) begin
            state_s[k] = PRESSED;
          end else if (cnt_r[k] == DEB_LAST) begin
            state_s[k] = IDLE;
          end else begin
            cnt_s[k] = cnt_r[k] + DEB_ONE;
          end
        end
        default: begin
          state_s[k] = IDLE;
          cnt_s[k]   = DEB_ZERO;
        end
      endcase
    end
  end

  // Arbitration: clear, then simultaneous, then single entry, then single exit
  always_comb begin
    now_s     = now_r;
    sum_s     = sum_r;
    in_ack_s  = 1'b0;
    out_ack_s = 1'b0;
    reject_s  = 1'b0;
    if (bus.clr) begin
      now_s = 6'd0;
      sum_s = 10'd0;
    end else if (ev_r[0] && ev_r[1]) begin
      sum_s    = sum_inc(sum_r);
      in_ack_s = 1'b1;
      if (now_r != 6'd0) begin
        out_ack_s = 1'b1;
      end else begin
        now_s = 6'd1;
      end
    end else if (ev_r[0]) begin
      if (now_r < CAP) begin
        now_s    = now_r + 6'd1;
        sum_s    = sum_inc(sum_r);
        in_ack_s = 1'b1;
      end else begin
        reject_s = 1'b1;
      end
    end else if (ev_r[1]) begin
      if (now_r != 6'd0) begin
        now_s     = now_r - 6'd1;
        out_ack_s = 1'b1;
      end else begin
        now_s = now_r;
      end
    end else begin
      now_s = now_r;
    end
  end

  // Counter, full flag and acknowledge registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      now_r     <= 6'd0;
      sum_r     <= 10'd0;
      full_r    <= 1'b0;
      in_ack_r  <= 1'b0;
      out_ack_r <= 1'b0;
      reject_r  <= 1'b0;
    end else begin
      now_r     <= now_s;
      sum_r     <= sum_s;
      full_r    <= (now_s == CAP);
      in_ack_r  <= in_ack_s;
      out_ack_r <= out_ack_s;
      reject_r  <= reject_s;
    end
  end

  // Free-running scan divider; the tick is registered so it lands TICK_DIV edges after release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt_r  <= TW'(1'b0);
      scan_tick_r <= 1'b0;
    end else begin
      tick_cnt_r  <= (tick_cnt_r == TICK_LAST) ? TW'(1'b0) : tick_cnt_r + TW'(1'b1);
      scan_tick_r <= (tick_cnt_r == TICK_LAST);
    end
  end

  assign bus.now_num   = now_r;
  assign bus.sum_num   = sum_r;
  assign bus.full_led  = full_r;
  assign bus.in_ack    = in_ack_r;
  assign bus.out_ack   = out_ack_r;
  assign bus.reject    = reject_r;
  assign bus.scan_tick = scan_tick_r;
endmodule

// File: tb/tb_occupancy_ctrl.sv
// Scoreboard bench for occupancy_ctrl with CAPACITY=3, DEB_CYCLES=4, TICK_DIV=8.
module tb_occupancy_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   edge_cnt;
  logic exp_tick;

  typedef struct packed {
    logic       in_ack;
    logic       out_ack;
    logic       reject;
    logic [5:0] now;
    logic [9:0] sum;
    logic       full;
  } resp_t;

  resp_t exp_q[$];
  resp_t act_m, exp_m;

  occupancy_if bus ();

  occupancy_ctrl #(.CAPACITY(3), .DEB_CYCLES(4), .TICK_DIV(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic expect_ev(input logic i, input logic o, input logic r,
                           input logic [5:0] n, input logic [9:0] s, input logic f);
    exp_q.push_back('{in_ack: i, out_ack: o, reject: r, now: n, sum: s, full: f});
  endtask

  task automatic press(input logic ki, input logic ko);
    @(negedge clk);
    bus.key_in  = ki;
    bus.key_out = ko;
    repeat (8) @(negedge clk);
    bus.key_in  = 1'b0;
    bus.key_out = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  // Event monitor: every ack/reject pulse must match the next queued expectation
  always @(negedge clk) begin
    if (rst_n && (bus.in_ack || bus.out_ack || bus.reject)) begin
      act_m = '{in_ack: bus.in_ack, out_ack: bus.out_ack, reject: bus.reject,
                now: bus.now_num, sum: bus.sum_num, full: bus.full_led};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event actual in=%0b out=%0b rej=%0b now=%0d sum=%0d full=%0b required none",
                 act_m.in_ack, act_m.out_ack, act_m.reject, act_m.now, act_m.sum, act_m.full);
      end else begin
        exp_m = exp_q.pop_front();
        if (act_m !== exp_m) begin
          errors++;
          $display("FAIL event actual in=%0b out=%0b rej=%0b now=%0d sum=%0d full=%0b required in=%0b out=%0b rej=%0b now=%0d sum=%0d full=%0b",
                   act_m.in_ack, act_m.out_ack, act_m.reject, act_m.now, act_m.sum, act_m.full,
                   exp_m.in_ack, exp_m.out_ack, exp_m.reject, exp_m.now, exp_m.sum, exp_m.full);
        end
      end
    end
  end

  // Scan tick reference: high after every 8th edge since reset release
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_cnt <= 0;
    else        edge_cnt <= edge_cnt + 1;
  end

  always @(negedge clk) begin
    if (rst_n) begin
      exp_tick = (edge_cnt > 0) && (edge_cnt % 8 == 0);
      checks++;
      if (bus.scan_tick !== exp_tick) begin
        errors++;
        $display("FAIL scan_tick edge=%0d actual=%0b required=%0b", edge_cnt, bus.scan_tick, exp_tick);
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.key_in  = 1'b0;
    bus.key_out = 1'b0;
    bus.clr     = 1'b0;
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_now", {10'd0, bus.now_num}, 16'd0);
    chk("rst_sum", {6'd0, bus.sum_num}, 16'd0);
    chk("rst_flags", {10'd0, bus.full_led, bus.in_ack, bus.out_ack, bus.reject, bus.scan_tick, 1'b0}, 16'd0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // First entry: ack appears exactly after edge 7 of a held key
    @(negedge clk);
    expect_ev(1'b1, 1'b0, 1'b0, 6'd1, 10'd1, 1'b0);
    bus.key_in = 1'b1;
    repeat (7) @(negedge clk);
    chk("lat_edge6_in_ack", {15'd0, bus.in_ack}, 16'd0);
    @(negedge clk);
    chk("lat_edge7_in_ack", {15'd0, bus.in_ack}, 16'd1);
    bus.key_in = 1'b0;
    repeat (10) @(negedge clk);

    // Asynchronous reset mid-cycle and mid-debounce
    bus.key_in = 1'b1;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_now", {10'd0, bus.now_num}, 16'd0);
    chk("async_rst_sum", {6'd0, bus.sum_num}, 16'd0);
    chk("async_rst_flags", {10'd0, bus.full_led, bus.in_ack, bus.out_ack, bus.reject, bus.scan_tick, 1'b0}, 16'd0);
    bus.key_in = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_now", {10'd0, bus.now_num}, 16'd0);

    // Bouncy press and bouncy release yield one entry
    expect_ev(1'b1, 1'b0, 1'b0, 6'd1, 10'd1, 1'b0);
    repeat (3) begin
      bus.key_in = 1'b1; repeat (3) @(negedge clk);
      bus.key_in = 1'b0; @(negedge clk);
    end
    bus.key_in = 1'b1; repeat (10) @(negedge clk);
    repeat (3) begin
      bus.key_in = 1'b0; repeat (3) @(negedge clk);
      bus.key_in = 1'b1; @(negedge clk);
    end
    bus.key_in = 1'b0; repeat (10) @(negedge clk);
    chk("bounce_now", {10'd0, bus.now_num}, 16'd1);

    // Fill to capacity, refuse, then leave
    expect_ev(1'b1, 1'b0, 1'b0, 6'd2, 10'd2, 1'b0); press(1'b1, 1'b0);
    expect_ev(1'b1, 1'b0, 1'b0, 6'd3, 10'd3, 1'b1); press(1'b1, 1'b0);
    expect_ev(1'b0, 1'b0, 1'b1, 6'd3, 10'd3, 1'b1); press(1'b1, 1'b0);
    expect_ev(1'b0, 1'b1, 1'b0, 6'd2, 10'd3, 1'b0); press(1'b0, 1'b1);
    expect_ev(1'b1, 1'b0, 1'b0, 6'd3, 10'd4, 1'b1); press(1'b1, 1'b0);
    expect_ev(1'b1, 1'b1, 1'b0, 6'd3, 10'd5, 1'b1); press(1'b1, 1'b1);
    expect_ev(1'b0, 1'b1, 1'b0, 6'd2, 10'd5, 1'b0); press(1'b0, 1'b1);
    expect_ev(1'b0, 1'b1, 1'b0, 6'd1, 10'd5, 1'b0); press(1'b0, 1'b1);
    expect_ev(1'b0, 1'b1, 1'b0, 6'd0, 10'd5, 1'b0); press(1'b0, 1'b1);
    press(1'b0, 1'b1);
    chk("exit_at_empty_now", {10'd0, bus.now_num}, 16'd0);
    expect_ev(1'b1, 1'b0, 1'b0, 6'd1, 10'd6, 1'b0); press(1'b1, 1'b1);

    // Simultaneous presses at now=1 advance the total up to 999, then wrap
    for (int i = 7; i <= 999; i++) begin
      expect_ev(1'b1, 1'b1, 1'b0, 6'd1, 10'(i), 1'b0);
      press(1'b1, 1'b1);
    end
    chk("preload_sum", {6'd0, bus.sum_num}, 16'd999);
    expect_ev(1'b1, 1'b0, 1'b0, 6'd2, 10'd0, 1'b0); press(1'b1, 1'b0);
    expect_ev(1'b1, 1'b0, 1'b0, 6'd3, 10'd1, 1'b1); press(1'b1, 1'b0);

    // Clear on the same edge as an entry event drops the event
    @(negedge clk);
    bus.key_in = 1'b1;
    repeat (7) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr    = 1'b0;
    bus.key_in = 1'b0;
    repeat (10) @(negedge clk);
    chk("clr_now", {10'd0, bus.now_num}, 16'd0);
    chk("clr_sum", {6'd0, bus.sum_num}, 16'd0);
    chk("clr_full", {15'd0, bus.full_led}, 16'd0);

    repeat (30) @(negedge clk);
    chk("queue_drained", 16'(exp_q.size()), 16'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
